// File: rtl/adder_pkg.sv
// Shared definitions for the prefix-adder family: operation encoding and
// helpers that size the prefix tree and place its pipeline registers.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int MIN_WIDTH = 4;
  localparam int MAX_WIDTH = 64;

  function automatic int level_count(input int width);
    return $clog2(width);
  endfunction

  // Level after which inner register k sits: ceil(k*levels/stages).
  function automatic int boundary_level(input int k, input int levels, input int stages);
    return (k * levels + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/prefix_black_cell.sv
// Kogge-Stone black cell: merges a higher (generate, propagate) pair with
// the adjacent lower group.
module prefix_black_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);

  assign g = g_hi | (p_hi & g_lo);
  assign p = p_hi & p_lo;

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor. A single advance enable moves every
// stage at once, so backpressure freezes the whole pipe without skid buffers.
module prefix_adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int LOG = level_count(WIDTH);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("prefix_adder_pipe: WIDTH must be a power of two in 4..64");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > LOG + 1) begin : g_bad_stages
    $error("prefix_adder_pipe: PIPE_STAGES must be in 1..clog2(WIDTH)+1");
  end

  function automatic bit is_boundary(input int lvl);
    for (int k = 1; k < PIPE_STAGES; k++) begin
      if (boundary_level(k, LOG, PIPE_STAGES) == lvl) return 1'b1;
    end
    return 1'b0;
  endfunction

  logic             adv;
  logic             sub;
  logic [WIDTH-1:0] b_eff;

  // Per-level view of the datapath after any register at that level.
  logic [WIDTH-1:0] g_post  [LOG+1];
  logic [WIDTH-1:0] p_post  [LOG+1];
  logic [WIDTH-1:0] sp_post [LOG+1];
  logic             cin_post[LOG+1];
  logic             v_post  [LOG+1];

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  assign sub         = (op_e'(in_op) == OP_SUB);
  assign b_eff       = in_b ^ {WIDTH{sub}};
  assign g_post[0]   = in_a & b_eff;
  assign p_post[0]   = in_a ^ b_eff;
  assign sp_post[0]  = in_a ^ b_eff;
  assign cin_post[0] = in_cin ^ sub;
  assign v_post[0]   = in_valid;

  for (genvar l = 1; l <= LOG; l++) begin : g_level
    localparam int SPAN = 1 << (l - 1);
    logic [WIDTH-1:0] g_lvl;
    logic [WIDTH-1:0] p_lvl;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= SPAN) begin : g_cell
        prefix_black_cell u_cell (
          .g_hi (g_post[l-1][i]),
          .p_hi (p_post[l-1][i]),
          .g_lo (g_post[l-1][i-SPAN]),
          .p_lo (p_post[l-1][i-SPAN]),
          .g    (g_lvl[i]),
          .p    (p_lvl[i])
        );
      end else begin : g_pass
        assign g_lvl[i] = g_post[l-1][i];
        assign p_lvl[i] = p_post[l-1][i];
      end
    end

    if (is_boundary(l)) begin : g_reg
      logic [WIDTH-1:0] g_q, p_q, sp_q;
      logic             cin_q, v_q;

      always_ff @(posedge clk) begin
        if (rst)      v_q <= 1'b0;
        else if (adv) v_q <= v_post[l-1];
      end

      always_ff @(posedge clk) begin
        if (adv) begin
          g_q   <= g_lvl;
          p_q   <= p_lvl;
          sp_q  <= sp_post[l-1];
          cin_q <= cin_post[l-1];
        end
      end

      assign g_post[l]   = g_q;
      assign p_post[l]   = p_q;
      assign sp_post[l]  = sp_q;
      assign cin_post[l] = cin_q;
      assign v_post[l]   = v_q;
    end else begin : g_comb
      assign g_post[l]   = g_lvl;
      assign p_post[l]   = p_lvl;
      assign sp_post[l]  = sp_post[l-1];
      assign cin_post[l] = cin_post[l-1];
      assign v_post[l]   = v_post[l-1];
    end
  end

  // Carry-in enters as the group below bit 0: C_i = G_i | P_i & cin.
  logic [WIDTH-1:0] carry, carry_in, sum_next;

  assign carry    = g_post[LOG] | (p_post[LOG] & {WIDTH{cin_post[LOG]}});
  assign carry_in = {carry[WIDTH-2:0], cin_post[LOG]};
  assign sum_next = sp_post[LOG] ^ carry_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
    end else if (adv) begin
      out_valid <= v_post[LOG];
      if (v_post[LOG]) begin
        out_sum  <= sum_next;
        out_cout <= carry[WIDTH-1];
        out_ovf  <= carry[WIDTH-1] ^ carry[WIDTH-2];
        out_zero <= (sum_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Directed bench for prefix_adder_pipe: a 32-bit/2-stage instance for the
// arithmetic and handshake cases, plus three extra width/depth configurations.
module tb_prefix_adder_pipe;
  import adder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_cin, in_op;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready, out_cout, out_ovf, out_zero;
  logic [31:0] out_sum;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  prefix_adder_pipe #(.WIDTH(32), .PIPE_STAGES(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  function automatic int cfg_width(input int j);
    return (j == 0) ? 4 : (j == 1) ? 8 : 64;
  endfunction

  function automatic int cfg_stages(input int j);
    return (j == 0) ? 1 : (j == 1) ? 4 : 7;
  endfunction

  function automatic logic [63:0] w_mask(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  // Reference: returns {ovf, cout, sum} using plain wide arithmetic.
  function automatic logic [65:0] ref_model(input int w, input logic [63:0] a,
                                            input logic [63:0] b, input logic cin,
                                            input logic op);
    logic [63:0] m, am, bm, s;
    logic [64:0] full;
    logic        cc, ovf;
    m    = w_mask(w);
    am   = a & m;
    bm   = op ? (~b & m) : (b & m);
    cc   = op ? ~cin : cin;
    full = {1'b0, am} + {1'b0, bm} + {64'd0, cc};
    s    = full[63:0] & m;
    ovf  = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
    return {ovf, full[w], s};
  endfunction

  logic        x_valid, x_cin, x_op;
  logic        x_ready = 1'b1;
  logic [63:0] x_a, x_b;
  logic        x_in_ready [3];
  logic        x_out_valid[3];
  logic [63:0] x_sum      [3];
  logic        x_cout     [3];
  logic        x_ovf      [3];
  logic        x_zero     [3];

  for (genvar j = 0; j < 3; j++) begin : g_x
    localparam int W  = cfg_width(j);
    localparam int PS = cfg_stages(j);
    prefix_adder_pipe #(.WIDTH(W), .PIPE_STAGES(PS)) u_x (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (x_valid),
      .in_ready  (x_in_ready[j]),
      .in_a      (x_a[W-1:0]),
      .in_b      (x_b[W-1:0]),
      .in_cin    (x_cin),
      .in_op     (x_op),
      .out_valid (x_out_valid[j]),
      .out_ready (x_ready),
      .out_sum   (x_sum[j][W-1:0]),
      .out_cout  (x_cout[j]),
      .out_ovf   (x_ovf[j]),
      .out_zero  (x_zero[j])
    );
  end

  task automatic checkOutput(input string tag, input logic [79:0] observed,
                             input logic [79:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic expectResult(input string tag, input logic [31:0] sum,
                              input logic cout, input logic ovf, input logic zero);
    checkOutput(tag, {out_valid, out_cout, out_ovf, out_zero, out_sum},
                {1'b1, cout, ovf, zero, sum});
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic cin, input op_e op);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_op    = op;
  endtask

  logic [63:0] tab_a  [8];
  logic [63:0] tab_b  [8];
  logic        tab_cin[8];
  int          res_cnt[3];
  int          first_c[3];
  int          last_c [3];

  initial begin
    logic [65:0] exp_v;
    logic [63:0] m;

    rst       = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, OP_ADD);
    x_valid = 1'b0; x_a = '0; x_b = '0; x_cin = 1'b0; x_op = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_outputs", {out_valid, out_cout, out_ovf, out_zero, out_sum}, 80'd0);
    checkOutput("reset_in_ready", in_ready, 1);

    // Wrap-around add, with a one-cycle gap before the result shows.
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, OP_ADD);
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, OP_ADD);
    checkOutput("t1_not_yet_valid", out_valid, 0);
    @(negedge clk);
    expectResult("t1_wrap", 32'h0, 1'b1, 1'b0, 1'b1);

    applyStimulus(1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, OP_ADD);
    @(negedge clk);
    applyStimulus(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, OP_ADD);
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, OP_ADD);
    expectResult("t2_pos_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    expectResult("t2_neg_ovf", 32'h0, 1'b1, 1'b1, 1'b1);

    applyStimulus(1'b1, 32'd5, 32'd3, 1'b0, OP_SUB);
    @(negedge clk);
    applyStimulus(1'b1, 32'd3, 32'd5, 1'b0, OP_SUB);
    @(negedge clk);
    applyStimulus(1'b1, 32'd5, 32'd3, 1'b1, OP_SUB);
    expectResult("t3_sub_5_3", 32'd2, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, OP_ADD);
    expectResult("t3_sub_3_5", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    expectResult("t3_sub_borrow_in", 32'd1, 1'b1, 1'b0, 1'b0);

    // Fill the pipe with the consumer stalled, then release it.
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'd1, 32'd2, 1'b0, OP_ADD);
    @(negedge clk);
    applyStimulus(1'b1, 32'd10, 32'd20, 1'b0, OP_ADD);
    @(negedge clk);
    applyStimulus(1'b1, 32'd100, 32'd200, 1'b0, OP_ADD);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t5_in_ready_low", in_ready, 0);
      expectResult("t5_held", 32'd3, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    expectResult("t5_held_last", 32'd3, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, OP_ADD);
    expectResult("t5_drain_b", 32'd30, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    expectResult("t5_drain_c", 32'd300, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t5_no_dup", out_valid, 0);

    // Reset with two ops in flight.
    applyStimulus(1'b1, 32'd1, 32'd1, 1'b0, OP_ADD);
    @(negedge clk);
    applyStimulus(1'b1, 32'd4, 32'd4, 1'b0, OP_ADD);
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, OP_ADD);
    expectResult("t6_pre_reset", 32'd2, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t6_reset_outputs", {out_valid, out_cout, out_ovf, out_zero, out_sum}, 80'd0);
    checkOutput("t6_reset_in_ready", in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t6_no_stale", out_valid, 0);
    end

    // Back-to-back alternating ADD/SUB through the other configurations.
    tab_a   = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h7777_7777_7777_7777,
                64'h8888_8888_8888_8888, 64'hDEAD_BEEF_CAFE_F00D, 64'h5,
                64'h8000_0000_0000_0000, 64'h0F0F_0F0F_0F0F_0F0F};
    tab_b   = '{64'h1, 64'h1, 64'h1111_1111_1111_1111, 64'h0123_4567_89AB_CDEF,
                64'h2152_4110_3501_0FF3, 64'h5, 64'h8000_0000_0000_0000,
                64'hF0F0_F0F0_F0F0_F0F0};
    tab_cin = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int j = 0; j < 3; j++) begin
      res_cnt[j] = 0;
      first_c[j] = -1;
      last_c[j]  = -1;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        if (x_out_valid[j]) begin
          if (res_cnt[j] < 8) begin
            m     = w_mask(cfg_width(j));
            exp_v = ref_model(cfg_width(j), tab_a[res_cnt[j]], tab_b[res_cnt[j]],
                              tab_cin[res_cnt[j]], res_cnt[j][0]);
            checkOutput($sformatf("t4_w%0d_op%0d", cfg_width(j), res_cnt[j]),
                        {x_zero[j], x_ovf[j], x_cout[j], x_sum[j] & m},
                        {(exp_v[63:0] == 64'd0), exp_v});
          end
          if (res_cnt[j] == 0) first_c[j] = c;
          last_c[j] = c;
          res_cnt[j]++;
        end
      end
      if (c < 8) begin
        x_valid = 1'b1;
        x_a     = tab_a[c];
        x_b     = tab_b[c];
        x_cin   = tab_cin[c];
        x_op    = c[0];
      end else begin
        x_valid = 1'b0;
      end
    end
    for (int j = 0; j < 3; j++) begin
      checkOutput($sformatf("t4_w%0d_count", cfg_width(j)), res_cnt[j], 8);
      checkOutput($sformatf("t4_w%0d_latency", cfg_width(j)), first_c[j], cfg_stages(j));
      checkOutput($sformatf("t4_w%0d_consecutive", cfg_width(j)), last_c[j] - first_c[j], 7);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/prefix_adder_pipe.md
Name: prefix_adder_pipe

Overview:
Parametrised, pipelined Kogge-Stone prefix adder/subtractor. It is the successor to the fixed 32-bit combinational prefix adder. It adds generic width, configurable pipeline depth, ADD/SUB mode, status flags and a valid/ready handshake with backpressure. It sits between an operand-issuing datapath and a result consumer, and sustains one operation per cycle.

Parameters:
WIDTH, 32, operand/result width; power of two, 4..64; any other value is an elaboration error.
PIPE_STAGES, 2, register stages from accept to result; 1..clog2(WIDTH)+1; any other value is an elaboration error.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand set present.
in_ready  output  1  block can accept this cycle.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_cin  input  1  carry-in (ADD) / borrow-in (SUB).
in_op  input  1  0 = ADD, 1 = SUB (op_e from package).
out_valid  output  1  result present.
out_ready  input  1  consumer accepts result.
out_sum  output  WIDTH  result.
out_cout  output  1  carry-out; for SUB, 1 = no borrow.
out_ovf  output  1  signed overflow.
out_zero  output  1  out_sum == 0.

Behaviour:
- Arithmetic:
  - ADD: sum = a + b + cin.
  - SUB: sum = a + ~b + ~cin, i.e. a - b - cin.
  - out_cout is the carry out of bit WIDTH-1.
  - out_ovf = carry into MSB XOR carry out of MSB.
  - All results are modulo 2^WIDTH.
- Prefix tree:
  - Level 0 forms g_i = a_i & b'_i and p_i = a_i ^ b'_i, where b' is b (ADD) or ~b (SUB).
  - cin is treated as g_{-1}.
  - There are LOG = clog2(WIDTH) black-cell levels at span 1, 2, 4, ... 2^(LOG-1).
  - Sum: sum_i = p_i ^ G_{i-1}.
- Register placement:
  - Inner boundaries sit after level ceil(k*LOG/PIPE_STAGES) for k = 1..PIPE_STAGES-1.
  - The final register is at the outputs.
  - PIPE_STAGES = 1 means the whole tree is combinational into the output register.
- Latency: an op accepted at edge N, with no stall, has out_valid = 1 after edge N+PIPE_STAGES-1, i.e. PIPE_STAGES cycles.
- Handshake:
  - Accept when in_valid & in_ready.
  - Result is consumed when out_valid & out_ready.
  - Global advance enable adv = ~out_valid | out_ready.
  - in_ready = adv; it is combinational from out_ready and out_valid only, never from in_valid.
  - On adv, every stage register and its valid bit shift forward; a non-accepted cycle inserts a bubble (valid = 0).
  - When adv = 0, all stages hold, and out_* stay stable until consumed.
  - Ordering is strict FIFO. No op is lost or duplicated.
- Throughput: 1 op/cycle while out_ready = 1.
- Simultaneous events: accept at input and consume at output in the same cycle is legal and required at full rate.
- Reset:
  - rst clears all stage valid bits.
  - Values after reset: out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0, out_zero = 0.
  - in_ready = 1 in the first cycle after reset.
  - Reset mid-operation discards every in-flight op; none emerges later.
  - Data registers other than the outputs need no reset.
- in_op and in_cin are carried with their operands; mode changes between consecutive ops need no bubble.

Decomposition:
- Shared package adder_pkg:
  - typedef enum logic {OP_ADD, OP_SUB} op_e.
  - localparam helper for level count.
  - function returning the register-boundary level for stage k.
  - The package is reused by future multi-operand adders.
- One sub-module, prefix_black_cell:
  - Inputs (g_hi, p_hi, g_lo, p_lo).
  - Outputs G = g_hi | p_hi & g_lo and P = p_hi & p_lo.
  - Instantiated by generate loops per level.
- Stage registers live in the top module.

Test Plan (WIDTH=32, PIPE_STAGES=2 unless stated):
1. ADD 0xFFFFFFFF + 0x00000001, cin=0 -> sum 0x00000000, cout 1, zero 1, ovf 0; out_valid exactly 2 cycles after accept.
2. ADD 0x7FFFFFFF + 0x00000001, cin=0 -> sum 0x80000000, cout 0, ovf 1; then ADD 0x80000000 + 0x80000000 -> sum 0, cout 1, ovf 1, zero 1.
3. SUB 5 - 3, cin=0 -> sum 2, cout 1. SUB 3 - 5 -> 0xFFFFFFFE, cout 0, ovf 0. SUB 5 - 3, cin=1 -> sum 1.
4. Issue 8 back-to-back ops with alternating ADD/SUB and out_ready=1 -> 8 results on 8 consecutive cycles, in order, matching a reference model. Repeat for WIDTH in {4,8,64} and PIPE_STAGES in {1, LOG+1}.
5. Pipeline full, out_ready=0 for 3 cycles -> in_ready=0 and out_* held bit-stable; after release, all results drain in order with no loss or duplication.
6. rst asserted for 1 cycle with 2 ops in flight -> next cycle out_valid=0, in_ready=1, outputs zero; no stale result appears over the following 5 cycles.
